time_entry_loader: RTL

//  Keypad-side writer for the level-3 countdown timer. Shifts BCD key digits into an M:SS entry register.

---
 rtl/time_entry_loader_pkg.sv | 35 +++
 rtl/time_entry_loader_if.sv | 37 +++
 rtl/time_entry_loader_sec_normalizer.sv | 57 +++++
 rtl/time_entry_loader.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/time_entry_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : time_entry_loader_pkg
// Purpose : Shared types and constants for the keypad time-entry loader.
//           State encoding, BCD limits and default timer limits.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package time_entry_loader_pkg;

  localparam logic [2:0] C_ST_IDLE  = 3'd0;
  localparam logic [2:0] C_ST_ENTRY = 3'd1;
  localparam logic [2:0] C_ST_LOAD  = 3'd2;
  localparam logic [2:0] C_ST_RUN   = 3'd3;
  localparam logic [2:0] C_ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = C_ST_IDLE,
    ST_ENTRY = C_ST_ENTRY,
    ST_LOAD  = C_ST_LOAD,
    ST_RUN   = C_ST_RUN,
    ST_DONE  = C_ST_DONE
  } state_e;

  localparam logic [3:0] BCD_NINE          = 4'd9;
  localparam int         SEC_LIMIT_DEFAULT = 60;
  localparam int         MIN_MAX_DEFAULT   = 9;

  // Key codes 10..15 are non-digit keys and must be ignored.
  function automatic logic is_bcd(input logic [3:0] code);
    return code <= BCD_NINE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/time_entry_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : time_entry_loader_if
// Purpose : Keypad/timer side bundle of the time-entry loader.
// Ports   : key_valid, key_code, start, cancel, timer_zero   (to loader)
//           min_data, sec_tens_data, sec_ones_data, carry_out,
//           loadn, run_en, entry_active, done                (from loader)
// Rev     : 1.0  initial release
// ============================================================================
interface time_entry_loader_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       start;
  logic       cancel;
  logic       timer_zero;
  logic [3:0] min_data;
  logic [3:0] sec_tens_data;
  logic [3:0] sec_ones_data;
  logic       carry_out;
  logic       loadn;
  logic       run_en;
  logic       entry_active;
  logic       done;

  modport master (
    output key_valid, key_code, start, cancel, timer_zero,
    input  min_data, sec_tens_data, sec_ones_data, carry_out,
    input  loadn, run_en, entry_active, done
  );

  modport slave (
    input  key_valid, key_code, start, cancel, timer_zero,
    output min_data, sec_tens_data, sec_ones_data, carry_out,
    output loadn, run_en, entry_active, done
  );
endinterface
`default_nettype wire

// File: rtl/time_entry_loader_sec_normalizer.sv
`default_nettype none
// ============================================================================
// Module  : sec_normalizer
// Purpose : Combinational M:SS normaliser. Seconds at/above SEC_LIMIT are
//           reduced by SEC_LIMIT and flagged for a minute carry; if minutes
//           are already at MIN_MAX the value is clamped to MIN_MAX:(LIMIT-1).
// Ports   : min_i/tens_i/ones_i  entered BCD digits
//           min_o/tens_o/ones_o  normalised BCD digits
//           carry_o              seconds overflowed (minute +1 wanted)
//           clamp_o              overflow could not be carried; value clamped
// Rev     : 1.0  initial release
// ============================================================================
module sec_normalizer #(
  parameter int SEC_LIMIT = 60,
  parameter int MIN_MAX   = 9
) (
  input  logic [3:0] min_i,
  input  logic [3:0] tens_i,
  input  logic [3:0] ones_i,
  output logic [3:0] min_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       carry_o,
  output logic       clamp_o
);
  // SEC_LIMIT is a multiple of ten, so subtracting it only touches the tens.
  localparam logic [3:0] C_LIMIT_TENS = 4'(SEC_LIMIT / 10);
  localparam logic [3:0] C_MAX_TENS   = 4'((SEC_LIMIT - 1) / 10);
  localparam logic [3:0] C_MAX_ONES   = 4'((SEC_LIMIT - 1) % 10);
  localparam logic [3:0] C_MIN_MAX    = 4'(MIN_MAX);

  logic [6:0] w_secs;
  logic       w_over;

  assign w_secs = 7'(tens_i) * 7'd10 + 7'(ones_i);
  assign w_over = (w_secs >= 7'(SEC_LIMIT));

  always_comb begin
    min_o   = min_i;
    tens_o  = tens_i;
    ones_o  = ones_i;
    carry_o = 1'b0;
    clamp_o = 1'b0;
    if (w_over) begin
      carry_o = 1'b1;
      if (min_i >= C_MIN_MAX) begin
        min_o   = C_MIN_MAX;
        tens_o  = C_MAX_TENS;
        ones_o  = C_MAX_ONES;
        clamp_o = 1'b1;
      end else begin
        tens_o  = tens_i - C_LIMIT_TENS;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/time_entry_loader.sv
`default_nettype none
// ============================================================================
// Module  : time_entry_loader
// Purpose : Keypad-side writer for the countdown timer. Shifts BCD digits
//           into an M:SS entry register, normalises and loads the timer on
//           start, runs it and closes the cook cycle on timer_zero.
// Ports   : clk     system clock
//           clearn  asynchronous active-low reset
//           bus     time_entry_loader_if.slave (keypad inputs, timer outputs)
// Rev     : 1.0  initial release
// ============================================================================
module time_entry_loader
  import time_entry_loader_pkg::*;
#(
  parameter int SEC_LIMIT = SEC_LIMIT_DEFAULT,
  parameter int MIN_MAX   = MIN_MAX_DEFAULT
) (
  input  logic                 clk,
  input  logic                 clearn,
  time_entry_loader_if.slave   bus
);
  state_e     state_q, state_d;
  logic [3:0] dig_min_q, dig_min_d, dig_tens_q, dig_tens_d, dig_ones_q, dig_ones_d;
  logic [3:0] min_data_q, min_data_d, tens_data_q, tens_data_d, ones_data_q, ones_data_d;
  logic       carry_q, carry_d, loadn_q, loadn_d, run_en_q, run_en_d;
  logic       entry_q, entry_d, done_q, done_d, first_run_q, first_run_d;

  logic [3:0] w_n_min, w_n_tens, w_n_ones;
  logic       w_n_carry, w_n_clamp, w_key_ok, w_all_zero;

  sec_normalizer #(
    .SEC_LIMIT (SEC_LIMIT),
    .MIN_MAX   (MIN_MAX)
  ) u_norm (
    .min_i   (dig_min_q),
    .tens_i  (dig_tens_q),
    .ones_i  (dig_ones_q),
    .min_o   (w_n_min),
    .tens_o  (w_n_tens),
    .ones_o  (w_n_ones),
    .carry_o (w_n_carry),
    .clamp_o (w_n_clamp)
  );

  assign w_key_ok   = bus.key_valid && is_bcd(bus.key_code);
  assign w_all_zero = (dig_min_q == 4'd0) && (dig_tens_q == 4'd0) && (dig_ones_q == 4'd0);

  always_comb begin
    state_d     = state_q;
    dig_min_d   = dig_min_q;
    dig_tens_d  = dig_tens_q;
    dig_ones_d  = dig_ones_q;
    min_data_d  = min_data_q;
    tens_data_d = tens_data_q;
    ones_data_d = ones_data_q;
    carry_d     = 1'b0;
    first_run_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!bus.cancel && w_key_ok) begin
          dig_min_d   = dig_tens_q;
          dig_tens_d  = dig_ones_q;
          dig_ones_d  = bus.key_code;
          state_d     = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (bus.cancel) begin
          state_d = ST_IDLE;
        end else if (bus.start) begin
          // A 0:00 entry is not a valid cook time; keep collecting digits.
          if (!w_all_zero) begin
            min_data_d  = w_n_min;
            tens_data_d = w_n_tens;
            ones_data_d = w_n_ones;
            // The timer cannot show 10 minutes, so a clamped value carries nothing.
            carry_d     = w_n_carry && !w_n_clamp;
            state_d     = ST_LOAD;
          end
        end else if (w_key_ok) begin
          dig_min_d  = dig_tens_q;
          dig_tens_d = dig_ones_q;
          dig_ones_d = bus.key_code;
        end
      end
      ST_LOAD: begin
        state_d     = ST_RUN;
        first_run_d = 1'b1;
      end
      ST_RUN: begin
        // The timer only becomes valid after its load settles, so the first
        // RUN cycle does not look at timer_zero.
        if (bus.cancel) begin
          state_d = ST_IDLE;
        end else if (!first_run_q && bus.timer_zero) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every way back to IDLE clears the entry and the displayed digits.
    if (state_d == ST_IDLE) begin
      dig_min_d   = 4'd0;
      dig_tens_d  = 4'd0;
      dig_ones_d  = 4'd0;
      min_data_d  = 4'd0;
      tens_data_d = 4'd0;
      ones_data_d = 4'd0;
    end

    // While entering, the data outputs mirror the entry register for display.
    if (state_d == ST_ENTRY) begin
      min_data_d  = dig_min_d;
      tens_data_d = dig_tens_d;
      ones_data_d = dig_ones_d;
    end

    loadn_d  = (state_d != ST_LOAD);
    run_en_d = (state_d == ST_RUN);
    entry_d  = (state_d == ST_ENTRY);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q     <= ST_IDLE;
      dig_min_q   <= 4'd0;
      dig_tens_q  <= 4'd0;
      dig_ones_q  <= 4'd0;
      min_data_q  <= 4'd0;
      tens_data_q <= 4'd0;
      ones_data_q <= 4'd0;
      carry_q     <= 1'b0;
      loadn_q     <= 1'b1;
      run_en_q    <= 1'b0;
      entry_q     <= 1'b0;
      done_q      <= 1'b0;
      first_run_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dig_min_q   <= dig_min_d;
      dig_tens_q  <= dig_tens_d;
      dig_ones_q  <= dig_ones_d;
      min_data_q  <= min_data_d;
      tens_data_q <= tens_data_d;
      ones_data_q <= ones_data_d;
      carry_q     <= carry_d;
      loadn_q     <= loadn_d;
      run_en_q    <= run_en_d;
      entry_q     <= entry_d;
      done_q      <= done_d;
      first_run_q <= first_run_d;
    end
  end

  assign bus.min_data      = min_data_q;
  assign bus.sec_tens_data = tens_data_q;
  assign bus.sec_ones_data = ones_data_q;
  assign bus.carry_out     = carry_q;
  assign bus.loadn         = loadn_q;
  assign bus.run_en        = run_en_q;
  assign bus.entry_active  = entry_q;
  assign bus.done          = done_q;
endmodule
`default_nettype wire
